// File: rtl/pdu_pkg.sv
// +-----------------------------------------------------------------------+
// | pdu_pkg : shared PDU types (key debouncer state encoding)              |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

package pdu_pkg;

   typedef enum logic [1:0] {
      KS_IDLE      = 2'd0,
      KS_PRESS_CHK = 2'd1,
      KS_HELD      = 2'd2,
      KS_REL_CHK   = 2'd3
   } ks_state_t;

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// +-----------------------------------------------------------------------+
// | key_debounce_ch : one debounced key channel, optional auto-repeat      |
// | (KEY_DEBOUNCE_REPEAT_EN). Revision: 1.0                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module key_debounce_ch
   import pdu_pkg::*;
#(
   parameter int STABLE       = 4,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic clk,
   input  logic rstn,
   input  logic tick,
   input  logic s,
   output logic level,
   output logic pulse
);

   localparam int CW = $clog2(STABLE);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

   generate
      if (STABLE < 2 || STABLE > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
         $error("key_debounce_ch: parameter out of range");
      end
   endgenerate

   ks_state_t     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          level_nxt, pulse_nxt;

`ifdef KEY_DEBOUNCE_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rcnt, rcnt_nxt, rcnt_inc, rtarget;
   logic          rphase, rphase_nxt;

   // rphase=0 waits out the initial delay, rphase=1 paces subsequent repeats
   assign rcnt_inc = rcnt + 1'b1;
   assign rtarget  = rphase ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level;
      pulse_nxt = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rcnt_nxt   = rcnt;
      rphase_nxt = rphase;
`endif
      if (tick) begin
         case (state)
            KS_IDLE: begin
               if (s) begin
                  state_nxt = KS_PRESS_CHK;
                  cnt_nxt   = CW'(1);
               end
            end
            KS_PRESS_CHK: begin
               if (!s) begin
                  state_nxt = KS_IDLE;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = KS_HELD;
                  cnt_nxt   = '0;
                  level_nxt = 1'b1;
                  pulse_nxt = 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                  rcnt_nxt   = '0;
                  rphase_nxt = 1'b0;
`endif
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            KS_HELD: begin
               if (!s) begin
                  state_nxt = KS_REL_CHK;
                  cnt_nxt   = CW'(1);
               end
`ifdef KEY_DEBOUNCE_REPEAT_EN
               else if (rcnt_inc == rtarget) begin
                  pulse_nxt  = 1'b1;
                  rcnt_nxt   = '0;
                  rphase_nxt = 1'b1;
               end else begin
                  rcnt_nxt = rcnt_inc;
               end
`endif
            end
            KS_REL_CHK: begin
               // A single high sample is a bounce: back to HELD without a pulse
               if (s) begin
                  state_nxt = KS_HELD;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = KS_IDLE;
                  cnt_nxt   = '0;
                  level_nxt = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                  rcnt_nxt   = '0;
                  rphase_nxt = 1'b0;
`endif
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = KS_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= KS_IDLE;
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= level_nxt;
         pulse <= pulse_nxt;
      end
   end

`ifdef KEY_DEBOUNCE_REPEAT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rcnt   <= '0;
         rphase <= 1'b0;
      end else begin
         rcnt   <= rcnt_nxt;
         rphase <= rphase_nxt;
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// +-----------------------------------------------------------------------+
// | key_debounce : W-channel push-button debouncer sampled on tick;        |
// | auto-repeat with KEY_DEBOUNCE_REPEAT_EN. Revision: 1.0                 |
// +-----------------------------------------------------------------------+
`default_nettype none

module key_debounce
   import pdu_pkg::*;
#(
   parameter int W            = 5,
   parameter int STABLE       = 4,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         tick,
   input  logic [W-1:0] key_in,
   output logic [W-1:0] key_level,
   output logic [W-1:0] key_pulse
);

   logic [W-1:0] sync_q1, sync_q2;

   // Synchronizer runs every clk so tick phase never widens the metastability window
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= key_in;
         sync_q2 <= sync_q1;
      end
   end

   generate
      for (genvar i = 0; i < W; i++) begin : g_ch
         key_debounce_ch #(
            .STABLE       (STABLE),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
         ) u_ch (
            .clk   (clk),
            .rstn  (rstn),
            .tick  (tick),
            .s     (sync_q2[i]),
            .level (key_level[i]),
            .pulse (key_pulse[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: W=2, STABLE=4, tick every 10 clk.
`timescale 1ns/1ps
`default_nettype none

module tb_key_debounce;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       tick;
   logic [1:0] key_in = 2'b00;
   logic [1:0] key_level;
   logic [1:0] key_pulse;

   int tcnt = 0;
   int pulses0 = 0;
   int pulses1 = 0;
   int errors = 0;
   int checks = 0;

   key_debounce #(
      .W            (2),
      .STABLE       (4),
      .REPEAT_DELAY (5),
      .REPEAT_RATE  (2)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .tick      (tick),
      .key_in    (key_in),
      .key_level (key_level),
      .key_pulse (key_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tcnt <= (tcnt == 9) ? 0 : tcnt + 1;
   assign tick = (tcnt == 9);

   always @(negedge clk) begin
      if (key_pulse[0]) pulses0++;
      if (key_pulse[1]) pulses1++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves us 1 ns after the edge that follows a tick edge (tcnt==0)
   task automatic align();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (tcnt == 0) break;
      end
   endtask

   task automatic test_reset();
      step(3);
      checks++;
      if (key_level !== 2'b00) begin
         errors++; $display("FAIL reset_level: got %b want 00", key_level);
      end
      checks++;
      if (key_pulse !== 2'b00) begin
         errors++; $display("FAIL reset_pulse: got %b want 00", key_pulse);
      end
      rstn = 1'b1;
      step(30);
      checks++;
      if (key_level !== 2'b00 || pulses0 != 0 || pulses1 != 0) begin
         errors++; $display("FAIL idle_quiet: level=%b p0=%0d p1=%0d want 00 0 0", key_level, pulses0, pulses1);
      end
   endtask

   task automatic test_clean_press();
      int p0, p1;
      align();
      p0 = pulses0; p1 = pulses1;
      key_in = 2'b01;
      step(39);
      checks++;
      if (key_level[0] !== 1'b0 || key_pulse[0] !== 1'b0) begin
         errors++; $display("FAIL press_early: level=%b pulse=%b want 0 0", key_level[0], key_pulse[0]);
      end
      step(1);
      checks++;
      if (key_level[0] !== 1'b1 || key_pulse[0] !== 1'b1) begin
         errors++; $display("FAIL press_accept: level=%b pulse=%b want 1 1", key_level[0], key_pulse[0]);
      end
      step(1);
      checks++;
      if (key_pulse[0] !== 1'b0 || key_level[0] !== 1'b1) begin
         errors++; $display("FAIL press_pulse_width: pulse=%b level=%b want 0 1", key_pulse[0], key_level[0]);
      end
      step(19);
      checks++;
      if (pulses0 - p0 != 1 || pulses1 - p1 != 0 || key_level[1] !== 1'b0) begin
         errors++; $display("FAIL press_count: p0=%0d p1=%0d lvl1=%b want 1 0 0", pulses0 - p0, pulses1 - p1, key_level[1]);
      end
      align();
      key_in = 2'b00;
      step(39);
      checks++;
      if (key_level[0] !== 1'b1) begin
         errors++; $display("FAIL release_early: level=%b want 1", key_level[0]);
      end
      step(1);
      checks++;
      if (key_level[0] !== 1'b0 || pulses0 - p0 != 1) begin
         errors++; $display("FAIL release_done: level=%b pulses=%0d want 0 1", key_level[0], pulses0 - p0);
      end
   endtask

   task automatic test_bounce();
      int p0;
      align();
      p0 = pulses0;
      key_in = 2'b01;
      step(10);
      key_in = 2'b00;
      step(10);
      key_in = 2'b01;
      step(39);
      checks++;
      if (key_level[0] !== 1'b0 || pulses0 != p0) begin
         errors++; $display("FAIL bounce_early: level=%b pulses=%0d want 0 0", key_level[0], pulses0 - p0);
      end
      step(1);
      checks++;
      if (key_level[0] !== 1'b1 || key_pulse[0] !== 1'b1) begin
         errors++; $display("FAIL bounce_accept: level=%b pulse=%b want 1 1", key_level[0], key_pulse[0]);
      end
      step(5);
      checks++;
      if (pulses0 - p0 != 1) begin
         errors++; $display("FAIL bounce_count: got %0d want 1", pulses0 - p0);
      end
   endtask

   task automatic test_release_bounce();
      int p0;
      align();
      p0 = pulses0;
      key_in = 2'b00;
      step(10);
      key_in = 2'b01;
      step(30);
      checks++;
      if (key_level[0] !== 1'b1 || pulses0 != p0) begin
         errors++; $display("FAIL rel_bounce: level=%b pulses=%0d want 1 0", key_level[0], pulses0 - p0);
      end
      align();
      key_in = 2'b00;
      step(39);
      checks++;
      if (key_level[0] !== 1'b1) begin
         errors++; $display("FAIL rel_early: level=%b want 1", key_level[0]);
      end
      step(1);
      checks++;
      if (key_level[0] !== 1'b0 || pulses0 != p0) begin
         errors++; $display("FAIL rel_done: level=%b pulses=%0d want 0 0", key_level[0], pulses0 - p0);
      end
   endtask

   task automatic test_simultaneous();
      align();
      key_in = 2'b11;
      step(39);
      checks++;
      if (key_pulse !== 2'b00) begin
         errors++; $display("FAIL simul_early: pulse=%b want 00", key_pulse);
      end
      step(1);
      checks++;
      if (key_pulse !== 2'b11 || key_level !== 2'b11) begin
         errors++; $display("FAIL simul_accept: pulse=%b level=%b want 11 11", key_pulse, key_level);
      end
      align();
      key_in = 2'b00;
      step(40);
      checks++;
      if (key_level !== 2'b00) begin
         errors++; $display("FAIL simul_release: level=%b want 00", key_level);
      end
   endtask

   task automatic test_reset_mid_hold();
      align();
      key_in = 2'b01;
      step(45);
      checks++;
      if (key_level[0] !== 1'b1) begin
         errors++; $display("FAIL rst_pre: level=%b want 1", key_level[0]);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (key_level !== 2'b00 || key_pulse !== 2'b00) begin
         errors++; $display("FAIL rst_async: level=%b pulse=%b want 00 00", key_level, key_pulse);
      end
      align();
      rstn = 1'b1;
      step(39);
      checks++;
      if (key_level[0] !== 1'b0 || key_pulse[0] !== 1'b0) begin
         errors++; $display("FAIL rst_requal_early: level=%b pulse=%b want 0 0", key_level[0], key_pulse[0]);
      end
      step(1);
      checks++;
      if (key_level[0] !== 1'b1 || key_pulse[0] !== 1'b1) begin
         errors++; $display("FAIL rst_requal: level=%b pulse=%b want 1 1", key_level[0], key_pulse[0]);
      end
      align();
      key_in = 2'b00;
      step(40);
   endtask

`ifdef KEY_DEBOUNCE_REPEAT_EN
   task automatic test_repeat();
      logic exp;
      align();
      key_in = 2'b01;
      step(40);
      for (int k = 0; k <= 12; k++) begin
         exp = (k == 0 || k == 5 || k == 7 || k == 9 || k == 11);
         checks++;
         if (key_pulse[0] !== exp) begin
            errors++; $display("FAIL repeat_tick%0d: pulse=%b want %b", k, key_pulse[0], exp);
         end
         if (k < 12) step(10);
      end
      align();
      key_in = 2'b00;
      step(40);
   endtask
`endif

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_bounce();
      test_simultaneous();
      test_reset_mid_hold();
`ifdef KEY_DEBOUNCE_REPEAT_EN
      test_repeat();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
